lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 146 ++++++++++++++
 tb/tb_lfsr_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//   Receive-side partner of the 8-bit Fibonacci LFSR pattern generator.
//   Hunts for the incoming LFSR stream, verifies LOCK_CNT consecutive correct
//   predictions, then free-runs its own predictor. While LOCKED it flags and
//   counts every mismatching sample.
//
// Optional feature (compile-time macro): LFSR_CHK_RESYNC_EN
//   When defined, LOSS_THRESH consecutive mismatches while LOCKED send the
//   checker back to HUNT. When undefined, only rst leaves LOCKED.
//
// Parameters
//   LOCK_CNT     consecutive correct predictions needed to lock (1..15)
//   LOSS_THRESH  consecutive LOCKED errors forcing a re-hunt (1..15)
//   CNT_W        width of the saturating error counter
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   in_data carries a sample this cycle
//   in_data    in   received LFSR state
//   clr_err    in   synchronous clear of err_cnt (wins over a coincident error)
//   locked     out  1 while the FSM is in LOCKED
//   err_pulse  out  one-cycle pulse per mismatch seen in LOCKED
//   err_cnt    out  saturating mismatch count
//   led        out  last accepted in_data
// All outputs are registered.
// ---------------------------------------------------------------------------
module lfsr_checker #(
  parameter int LOCK_CNT    = 4,
  parameter int LOSS_THRESH = 3,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       led
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [4:0] LOCK_CNT5 = 5'(LOCK_CNT);

  // Reject out-of-range configurations at elaboration.
  if (LOCK_CNT < 1 || LOCK_CNT > 15) begin : g_bad_lock_cnt
    $error("lfsr_checker: LOCK_CNT must be 1..15");
  end
  if (LOSS_THRESH < 1 || LOSS_THRESH > 15) begin : g_bad_loss_thresh
    $error("lfsr_checker: LOSS_THRESH must be 1..15");
  end

  // Generator's next-state function, including the escape from all-zeros.
  function automatic logic [7:0] nxt(input logic [7:0] s);
    if (s == 8'h00) return 8'h01;
    return {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
  endfunction

  state_t     state;
  logic [7:0] pred;
  logic [3:0] match;
  logic [4:0] match_inc;
  logic       hit;

  assign match_inc = {1'b0, match} + 5'd1;
  assign hit       = (in_data == pred);

`ifdef LFSR_CHK_RESYNC_EN
  localparam logic [4:0] LOSS5 = 5'(LOSS_THRESH);
  logic [3:0] consec;
  logic [4:0] consec_inc;
  assign consec_inc = {1'b0, consec} + 5'd1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      pred      <= 8'h00;
      match     <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      led       <= 8'h00;
`ifdef LFSR_CHK_RESYNC_EN
      consec    <= 4'd0;
`endif
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        led <= in_data;
        case (state)
          HUNT: begin
            pred  <= nxt(in_data);
            match <= 4'd0;
            state <= VERIFY;
          end
          VERIFY: begin
            // Until locked, every sample reseeds the predictor.
            pred <= nxt(in_data);
            if (hit) begin
              match <= match_inc[3:0];
              if (match_inc == LOCK_CNT5) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              match <= 4'd0;
            end
          end
          LOCKED: begin
            // Free-running: a corrupted word must not poison later predictions.
            pred <= nxt(pred);
            if (hit) begin
`ifdef LFSR_CHK_RESYNC_EN
              consec <= 4'd0;
`endif
            end else begin
              err_pulse <= 1'b1;
              if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
`ifdef LFSR_CHK_RESYNC_EN
              if (consec_inc == LOSS5) begin
                state  <= HUNT;
                locked <= 1'b0;
                consec <= 4'd0;
              end else begin
                consec <= consec_inc[3:0];
              end
`endif
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
      // Placed last so a clear beats a same-cycle increment.
      if (clr_err) err_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
module tb_lfsr_checker;
  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic        clk = 1'b0;
  logic        rst, in_valid, clr_err;
  logic [7:0]  in_data;
  logic        locked, err_pulse, s_locked, s_pulse;
  logic [15:0] err_cnt;
  logic [3:0]  s_cnt;
  logic [7:0]  led, s_led;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_THRESH(LOSS), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .led(led));

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  lfsr_checker #(.LOCK_CNT(LOCK), .LOSS_THRESH(LOSS), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_err(clr_err),
    .locked(s_locked), .err_pulse(s_pulse), .err_cnt(s_cnt), .led(s_led));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // LFSR next state: feedback is parity of taps 0,2,3,4 (mask 8'h1D).
  function automatic logic [7:0] nx(input logic [7:0] s);
    if (s == 8'h00) return 8'h01;
    return {^(s & 8'h1D), s[7:1]};
  endfunction

  // Reference model: phase 0=searching, 1=confirming, 2=locked.
  int         m_phase, m_good, m_bad, m_cnt, m_cnt_s;
  logic [7:0] m_expect, m_led;
  logic       m_pulse;

  task automatic model_reset();
    m_phase = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_cnt_s = 0;
    m_expect = 8'h00; m_led = 8'h00; m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic clr);
    m_pulse = 1'b0;
    if (v) begin
      m_led = d;
      if (m_phase == 0) begin
        m_expect = nx(d); m_good = 0; m_phase = 1;
      end else if (m_phase == 1) begin
        if (d == m_expect) begin
          m_good++;
          if (m_good == LOCK) begin m_phase = 2; m_bad = 0; end
        end else m_good = 0;
        m_expect = nx(d);
      end else begin
        if (d != m_expect) begin
          m_pulse = 1'b1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_s < 15) m_cnt_s++;
          m_bad++;
`ifdef LFSR_CHK_RESYNC_EN
          if (m_bad == LOSS) begin m_phase = 0; m_bad = 0; end
`endif
        end else m_bad = 0;
        m_expect = nx(m_expect);
      end
    end
    if (clr) begin m_cnt = 0; m_cnt_s = 0; end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".locked"},   locked,    (m_phase == 2));
    chk({ph, ".pulse"},    err_pulse, m_pulse);
    chk({ph, ".err_cnt"},  err_cnt,   m_cnt);
    chk({ph, ".led"},      led,       m_led);
    chk({ph, ".s_cnt"},    s_cnt,     m_cnt_s);
    chk({ph, ".s_locked"}, s_locked,  (m_phase == 2));
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic clr, input string ph);
    @(negedge clk);
    in_valid = v; in_data = d; clr_err = clr;
    @(posedge clk);
    model_step(v, d, clr);
    #1 compare_all(ph);
  endtask

  logic [7:0] g;

  task automatic send_good(input string ph, input bit gaps);
    if (gaps && $urandom_range(0, 3) == 0) step(1'b0, 8'($urandom), 1'b0, ph);
    step(1'b1, g, 1'b0, ph);
    g = nx(g);
  endtask

  task automatic send_bad(input logic clr, input string ph);
    step(1'b1, ~g, clr, ph);
    g = nx(g);
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clr_err = 1'b0;
    model_reset();
    #12;
    chk("reset.locked", locked, 1'b0);
    chk("reset.pulse", err_pulse, 1'b0);
    chk("reset.err_cnt", err_cnt, 16'h0);
    chk("reset.led", led, 8'h00);
    @(negedge clk); rst = 1'b0;

    // Random noise while hunting; the model decides whatever happens.
    for (int i = 0; i < 30; i++) step(1'($urandom), 8'($urandom), 1'b0, "noise");
    sync_reset();

    // 1: clean stream from seed 01, lock after 5th sample, then 200 with gaps.
    g = 8'h01;
    for (int i = 0; i < 4; i++) send_good("t1", 1'b0);
    chk("t1.not_yet_locked", locked, 1'b0);
    send_good("t1", 1'b0);
    chk("t1.locked_after_5", locked, 1'b1);
    for (int i = 0; i < 200; i++) send_good("t1", 1'b1);
    chk("t1.no_errors", err_cnt, 16'd0);

    // 2: one corrupted word while locked.
    send_bad(1'b0, "t2");
    chk("t2.pulse", err_pulse, 1'b1);
    chk("t2.err_cnt", err_cnt, 16'd1);
    for (int i = 0; i < 20; i++) send_good("t2", 1'b1);
    chk("t2.still_locked", locked, 1'b1);
    chk("t2.err_cnt_held", err_cnt, 16'd1);

    // 3: bad word in VERIFY at match=2 restarts the count from that word.
    sync_reset();
    g = 8'h37;
    for (int i = 0; i < 3; i++) send_good("t3", 1'b0);
    g = ~g;
    send_good("t3", 1'b0);
    for (int i = 0; i < 3; i++) send_good("t3", 1'b0);
    chk("t3.not_locked", locked, 1'b0);
    send_good("t3", 1'b0);
    chk("t3.locked", locked, 1'b1);
    chk("t3.err_cnt", err_cnt, 16'd0);

    // 4: three wrong words in a row while locked.
    for (int i = 0; i < 3; i++) send_bad(1'b0, "t4");
    chk("t4.err_cnt", err_cnt, 16'd3);
`ifdef LFSR_CHK_RESYNC_EN
    chk("t4.dropped", locked, 1'b0);
    g = 8'h5A;
`else
    chk("t4.held", locked, 1'b1);
`endif
    for (int i = 0; i < 5; i++) send_good("t4", 1'b0);
    chk("t4.relocked", locked, 1'b1);

    // 5: reach 7 errors, clear on an error cycle, then saturate the 4-bit copy.
    for (int i = 0; i < 4; i++) begin send_bad(1'b0, "t5"); send_good("t5", 1'b0); end
    chk("t5.err_cnt7", err_cnt, 16'd7);
    send_bad(1'b1, "t5");
    chk("t5.clr_wins", err_cnt, 16'd0);
    chk("t5.pulse_with_clr", err_pulse, 1'b1);
    send_good("t5", 1'b0);
    for (int i = 0; i < 20; i++) begin send_bad(1'b0, "t5s"); send_good("t5s", 1'b1); end
    chk("t5.sat15", s_cnt, 4'd15);
    chk("t5.wide20", err_cnt, 16'd20);
    send_bad(1'b0, "t5s");
    chk("t5.sat_hold", s_cnt, 4'd15);
    chk("t5.sat_pulse", s_pulse, 1'b1);

    // 6: async reset in a valid gap while locked.
    step(1'b0, 8'h00, 1'b0, "t6");
    @(negedge clk); #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6.async_locked", locked, 1'b0);
    chk("t6.async_cnt", err_cnt, 16'd0);
    chk("t6.async_led", led, 8'h00);
    chk("t6.async_s_cnt", s_cnt, 4'd0);
    @(posedge clk); #1 compare_all("t6.held");
    @(negedge clk); rst = 1'b0;
    g = 8'h00;
    for (int i = 0; i < 5; i++) send_good("t6", 1'b0);
    chk("t6.relock_from_00", locked, 1'b1);
    chk("t6.no_err", err_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
